// File: rtl/proposed_adder_pkg.sv
// Shared constants and helpers for the proposed_adder datapath.
package proposed_adder_pkg;

  localparam int DEFAULT_WIDTH       = 8;
  localparam int DEFAULT_APPROX_LSBS = 0;
  localparam int SUM_W               = DEFAULT_WIDTH + 1;

  function automatic int sum_width(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/proposed_adder_control.sv
// Carry-control stage: one control bit per sum position plus the carry-out.
module proposed_adder_control
  import proposed_adder_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int APPROX_LSBS = DEFAULT_APPROX_LSBS
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o,
  output logic             cout_o
);

  localparam int K   = APPROX_LSBS;
  localparam int KM1 = (K > 0) ? K - 1 : 0;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] y;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // The approximate part never propagates; only its top generate feeds bit K.
  always_comb begin
    y = '0;
    if (K > 0) begin
      y[K] = g[KM1];
    end
    for (int unsigned i = K + 1; i < WIDTH; i++) begin
      y[i] = g[i-1] | (p[i-1] & y[i-1]);
    end
  end

  assign y_o    = y;
  assign cout_o = g[WIDTH-1] | (p[WIDTH-1] & y[WIDTH-1]);

endmodule

// File: rtl/proposed_adder.sv
// Registered WIDTH-bit adder with modified-XOR sum cells and optional OR-approximated low bits.
module proposed_adder
  import proposed_adder_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int APPROX_LSBS = DEFAULT_APPROX_LSBS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   s,
  output logic             out_valid
);

  localparam int SW = sum_width(WIDTH);

  if (APPROX_LSBS < 0 || APPROX_LSBS >= WIDTH) begin : g_bad_param
    $error("proposed_adder: APPROX_LSBS must be in 0..WIDTH-1");
  end

  logic [WIDTH-1:0] y;
  logic             cout;
  logic [SW-1:0]    sum;
  logic [SW-1:0]    s_d, s_q;
  logic             out_valid_d, out_valid_q;

  proposed_adder_control #(
    .WIDTH      (WIDTH),
    .APPROX_LSBS(APPROX_LSBS)
  ) u_control (
    .a_i   (a),
    .b_i   (b),
    .y_o   (y),
    .cout_o(cout)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i < APPROX_LSBS) begin : g_approx
      assign sum[i] = a[i] | b[i];
    end else begin : g_exact
      assign sum[i] = a[i] ^ b[i] ^ y[i];
    end
  end
  assign sum[WIDTH] = cout;

  always_comb begin
    s_d         = s_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      s_d         = sum;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign s         = s_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_proposed_adder.sv
// Directed and random checks of proposed_adder, exact (k=0) and approximate (k=4) builds.
module tb_proposed_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W:0]   s0, s1;
  logic         ov0, ov1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  proposed_adder #(.WIDTH(W), .APPROX_LSBS(0)) dut_exact (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .s(s0), .out_valid(ov0)
  );

  proposed_adder #(.WIDTH(W), .APPROX_LSBS(4)) dut_approx (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .s(s1), .out_valid(ov1)
  );

  task automatic drive(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic v);
    @(negedge clk);
    a = aa;
    b = bb;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a = 8'd9; b = 8'd9; in_valid = 1'b1;
    #1;
    total++;
    if (s0 !== 9'd0 || ov0 !== 1'b0 || s1 !== 9'd0 || ov1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_initial: s0=%0d ov0=%b s1=%0d ov1=%b want 0/0", s0, ov0, s1, ov1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'd5, 8'd6, 1'b1);
    total++;
    if (s0 !== 9'd11 || ov0 !== 1'b1) begin
      bad++;
      $display("FAIL first_after_release: s=%0d ov=%b want 11/1", s0, ov0);
    end
    @(negedge clk);
    a = 8'd9; b = 8'd9; in_valid = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (s0 !== 9'd0 || ov0 !== 1'b0 || s1 !== 9'd0 || ov1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: s0=%0d ov0=%b s1=%0d ov1=%b want 0/0", s0, ov0, s1, ov1);
    end
    @(posedge clk);
    #1;
    total++;
    if (s0 !== 9'd0 || ov0 !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: s=%0d ov=%b want 0/0", s0, ov0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic test_exact();
    logic [W-1:0] av [5] = '{8'd16, 8'd11, 8'd255, 8'd0, 8'd255};
    logic [W-1:0] bv [5] = '{8'd15, 8'd21, 8'd255, 8'd0, 8'd1};
    logic [W:0]   ev [5] = '{9'd31, 9'd32, 9'h1FE, 9'd0, 9'd256};
    for (int i = 0; i < 5; i++) begin
      drive(av[i], bv[i], 1'b1);
      total++;
      if (s0 !== ev[i] || ov0 !== 1'b1) begin
        bad++;
        $display("FAIL exact[%0d] a=%0d b=%0d: s=%0d ov=%b want %0d/1", i, av[i], bv[i], s0, ov0, ev[i]);
      end
    end
  endtask

  task automatic test_approx();
    logic [W-1:0] av [3] = '{8'd16, 8'd11, 8'd255};
    logic [W-1:0] bv [3] = '{8'd15, 8'd21, 8'd255};
    logic [W:0]   ev [3] = '{9'd31, 9'd31, 9'd511};
    for (int i = 0; i < 3; i++) begin
      drive(av[i], bv[i], 1'b1);
      total++;
      if (s1 !== ev[i] || ov1 !== 1'b1) begin
        bad++;
        $display("FAIL approx[%0d] a=%0d b=%0d: s=%0d ov=%b want %0d/1", i, av[i], bv[i], s1, ov1, ev[i]);
      end
    end
  endtask

  task automatic test_valid_gating();
    logic [W-1:0] av [3] = '{8'd1, 8'd7, 8'd3};
    logic [W-1:0] bv [3] = '{8'd2, 8'd7, 8'd4};
    logic         vv [3] = '{1'b1, 1'b0, 1'b1};
    logic [W:0]   ev [3] = '{9'd3, 9'd3, 9'd7};
    for (int i = 0; i < 3; i++) begin
      drive(av[i], bv[i], vv[i]);
      total++;
      if (s0 !== ev[i] || ov0 !== vv[i] || s1 !== ev[i] || ov1 !== vv[i]) begin
        bad++;
        $display("FAIL valid_gating[%0d]: s0=%0d ov0=%b s1=%0d ov1=%b want %0d/%b",
                 i, s0, ov0, s1, ov1, ev[i], vv[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ra, rb;
    logic [W:0]   e0, e1;
    logic [4:0]   up;
    logic [3:0]   low;
    for (int i = 0; i < 10000; i++) begin
      ra = W'($urandom_range(255, 0));
      rb = W'($urandom_range(255, 0));
      e0 = {1'b0, ra} + {1'b0, rb};
      low = ra[3:0] | rb[3:0];
      up  = {1'b0, ra[7:4]} + {1'b0, rb[7:4]} + {4'b0, ra[3] & rb[3]};
      e1  = {up, low};
      drive(ra, rb, 1'b1);
      total++;
      if (s0 !== e0 || ov0 !== 1'b1 || s1 !== e1 || ov1 !== 1'b1) begin
        bad++;
        $display("FAIL random[%0d] a=%0d b=%0d: s0=%0d s1=%0d ov=%b%b want %0d/%0d/11",
                 i, ra, rb, s0, s1, ov0, ov1, e0, e1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_approx();
    test_valid_gating();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/proposed_adder.md
Name: proposed_adder

Overview:
- Registered WIDTH-bit adder for a spintronic image-processing datapath.
- A carry-control stage generates one control bit per position. A per-bit "modified XOR" cell (a ^ b ^ y) forms each sum bit.
- Optional approximate lower part: the low APPROX_LSBS bits use OR instead of a true sum, trading accuracy for energy. With the default of 0 the adder is exact.
- Sits between pixel-operand sources and downstream filter/accumulate stages.

Parameters:
- WIDTH, 8, operand width in bits; the sum is WIDTH+1 bits.
- APPROX_LSBS, 0, number of low bits computed approximately. Legal range is 0..WIDTH-1; any other value is a build-time error.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a/b valid this cycle
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- s  output  WIDTH+1  registered sum; s[WIDTH] is carry-out
- out_valid  output  1  s holds a fresh result

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset: s = 0 and out_valid = 0, applied immediately on rst_n falling, independent of clk.
  - Reset asserted mid-operation discards any pending result.
  - The first edge after rst_n deasserts behaves as a normal cycle.
- Latency 1: on a rising clk with in_valid=1, s <= f(a,b) and out_valid <= 1.
- With in_valid=0 on a rising clk: s holds its previous value and out_valid <= 0.
- No backpressure; a new operand pair is accepted every cycle.
- Control vector y[WIDTH-1:0], combinational, k = APPROX_LSBS:
  - Bits i < k: y[i] = 0.
  - Bit k: y[k] = a[k-1] & b[k-1] when k>0, else 0.
  - Bits i > k: y[i] = g[i-1] | (p[i-1] & y[i-1]), with g = a&b and p = a^b (ripple or lookahead, implementer's choice, same result).
- Sum bits:
  - i < k: s[i] = a[i] | b[i].
  - i >= k: s[i] = a[i] ^ b[i] ^ y[i].
- Carry-out s[WIDTH] = g[WIDTH-1] | (p[WIDTH-1] & y[WIDTH-1]); must be driven, never left floating.
- k=0: s == a + b exactly for all inputs, including all-ones (s = 2^(WIDTH+1) - 2).
- k>0: the error is confined to the lower part plus the dropped carry-propagate into bit k; the result is deterministic as defined above.
- No X propagation from reset values; all outputs are registered.

Decomposition:
- Shared package proposed_adder_pkg:
  - default WIDTH and APPROX_LSBS constants;
  - localparam SUM_W = WIDTH+1.
- One sub-module, proposed_adder_control:
  - inputs a, b; output y[WIDTH-1:0] and carry-out;
  - combinational.
- The modified-XOR bit cell is a 3-input XOR (or OR in the approximate part), inlined per bit with a generate loop.
- Top level holds only the output and valid registers.

Test Plan:
- Reset: assert rst_n=0 asynchronously between edges, with in_valid=1 -> s=0 and out_valid=0 immediately; both hold until release.
- Exact, WIDTH=8, k=0:
  - a=16, b=15 -> s=31 one cycle later, out_valid=1;
  - then a=11, b=21 -> s=32 (carry ripple through bits 0..4).
- Exact boundary: a=255, b=255 -> s=510 (9'h1FE); a=0, b=0 -> s=0; a=255, b=1 -> s=256 (carry-out only).
- Approx, k=4:
  - a=16, b=15 -> s=31;
  - a=11, b=21 -> s=31 (exact would be 32);
  - a=255, b=255 -> s=511.
- Valid gating: in_valid pattern 1,0,1 with operands (1,2), (7,7), (3,4) -> s sequence 3, 3 (held), 7; out_valid sequence 1, 0, 1.
- Random: 10k random operand pairs with k=0, compared against a+b; back-to-back every cycle with no mismatch.
